// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hold/flush control for the IF/ID and ID/EX pipeline registers and the PC.
// Handles load-use stalls, taken-branch squash from EX, and freezes the
// front end while a multi-cycle mul/div occupies EX. A saturating counter
// records how many cycles the PC was held.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_md_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             md_busy_o,
    output logic [7:0]       stall_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Bundle of pipeline-register controls driven each cycle
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_t;

    // BUSY spans MD_LATENCY-1 cycles; the final EX cycle of the op is spent in IDLE
    localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 1);
    localparam logic       MD_MULTI = (MD_LATENCY > 1);

    state_t     state;
    logic [3:0] cnt;
    logic       md_busy_q;
    logic [7:0] stall_cnt;
    logic       lu;
    logic       br;
    ctrl_t      ctrl;

    // Hazard detection; $zero is never a real dependency
    always_comb begin
        lu = ex_memread_i && (ex_rt_i != '0) &&
             ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        br = ex_branch_taken_i;
    end

    // Output priority: reset, busy freeze, branch squash, load-use stall
    always_comb begin
        ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                 idex_write: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0};
        if (!rst_i) begin
            ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                     idex_write: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b1};
        end else if (state == BUSY) begin
            // Front end frozen; EX keeps the op, EX/MEM receives bubbles
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_write  = 1'b0;
            ctrl.exmem_flush = 1'b1;
        end else if (br) begin
            // Wrong-path instructions in IF and ID are squashed
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (lu) begin
            // Hold PC and IF/ID one cycle, insert a bubble into EX
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_write_o  = ctrl.ifid_write;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_write_o  = ctrl.idex_write;
    assign idex_flush_o  = ctrl.idex_flush;
    assign exmem_flush_o = ctrl.exmem_flush;
    assign md_busy_o     = md_busy_q;
    assign stall_cnt_o   = stall_cnt;

    // Mul/div occupancy FSM; a squashed or stalled mul/div does not start
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            md_busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (id_md_i && !br && !lu && MD_MULTI) begin
                        state     <= BUSY;
                        cnt       <= CNT_INIT;
                        md_busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= IDLE;
                        md_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Count PC-held cycles, saturating at 255
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= 8'd0;
        end else if (!ctrl.pc_write && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table-driven per-cycle vectors with a
// scoreboard for control outputs and the stall counter, plus hand-written
// sequences for latency, reset-in-BUSY and counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
    logic       id_uses_rt_i, id_md_i, ex_memread_i, ex_branch_taken_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
    logic       idex_flush_o, exmem_flush_o, md_busy_o;
    logic [7:0] stall_cnt_o;

    pipe_hazard_ctrl #(.MD_LATENCY(4), .REG_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .id_md_i(id_md_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
        .ex_branch_taken_i(ex_branch_taken_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o), .idex_write_o(idex_write_o),
        .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
        .md_busy_o(md_busy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected control word: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f, busy}
    localparam logic [6:0] E_DEF  = 7'b1101000;
    localparam logic [6:0] E_LU   = 7'b0001100;
    localparam logic [6:0] E_BR   = 7'b1111100;
    localparam logic [6:0] E_BUSY = 7'b0000011;
    localparam logic [6:0] E_RST  = 7'b0010110;

    typedef struct {
        logic       md;
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [6:0]  ctrl_q[$];
    int          stall_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_stall = 0;

    function automatic vec_t mk(logic md, logic mr, logic [4:0] ex_rt, logic [4:0] rs,
                                logic [4:0] rt, logic ut, logic br, logic [6:0] exp);
        vec_t v;
        v.md = md; v.mr = mr; v.ex_rt = ex_rt; v.rs = rs;
        v.rt = rt; v.ut = ut; v.br = br; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] got_ctrl();
        return {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                idex_flush_o, exmem_flush_o, md_busy_o};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare controls, then compare stall count after the edge
    task automatic step(input vec_t v, input string name);
        logic [6:0] ec;
        int         es;
        @(negedge clk_i);
        id_md_i = v.md; ex_memread_i = v.mr; ex_rt_i = v.ex_rt; id_rs_i = v.rs;
        id_rt_i = v.rt; id_uses_rt_i = v.ut; ex_branch_taken_i = v.br;
        ctrl_q.push_back(v.exp);
        if (v.exp[6] == 1'b0 && exp_stall < 255) exp_stall++;
        stall_q.push_back(exp_stall);
        #1;
        ec = ctrl_q.pop_front();
        check({name, " ctrl"}, int'(got_ctrl()), int'(ec));
        @(posedge clk_i);
        #1;
        es = stall_q.pop_front();
        check({name, " stall_cnt"}, int'(stall_cnt_o), es);
    endtask

    task automatic idle_inputs();
        id_md_i = 0; ex_memread_i = 0; ex_rt_i = 0; id_rs_i = 0;
        id_rt_i = 0; id_uses_rt_i = 0; ex_branch_taken_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_stall = 0;
        #1;
        check("reset ctrl", int'(got_ctrl()), int'(E_RST));
        check("reset stall_cnt", int'(stall_cnt_o), 0);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_i = 1'b0;
        #2;
        check("por ctrl", int'(got_ctrl()), int'(E_RST));
        check("por stall_cnt", int'(stall_cnt_o), 0);
        check("por busy", int'(md_busy_o), 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        //          md mr ex_rt rs  rt  ut br exp
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_DEF));   // idle
        tbl.push_back(mk(0, 1, 8,  8,  0,  0, 0, E_LU));    // load-use on rs
        tbl.push_back(mk(0, 1, 0,  0,  0,  0, 0, E_DEF));   // $zero never stalls
        tbl.push_back(mk(0, 1, 5,  3,  5,  1, 0, E_LU));    // load-use on rt
        tbl.push_back(mk(0, 1, 5,  3,  5,  0, 0, E_DEF));   // rt not a source
        tbl.push_back(mk(0, 0, 8,  8,  8,  1, 0, E_DEF));   // not a load
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 1, E_BR));    // taken branch
        tbl.push_back(mk(0, 1, 8,  8,  0,  0, 1, E_BR));    // branch beats load-use
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 1, E_BR));    // branch squashes mul/div
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_DEF));   // no BUSY after squash
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, E_DEF));   // mul/div enters
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_DEF));   // final EX cycle in IDLE
        tbl.push_back(mk(1, 1, 9,  9,  0,  0, 0, E_LU));    // mul/div held by load-use
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, E_DEF));   // stall clears, enters
        tbl.push_back(mk(0, 1, 9,  9,  0,  0, 1, E_BUSY));  // hazards ignored in BUSY
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(1, 0, 0,  0,  0,  0, 0, E_DEF));   // exit cycle, back-to-back
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_BUSY));
        tbl.push_back(mk(0, 0, 0,  0,  0,  0, 0, E_DEF));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
        check("table total stalls", int'(stall_cnt_o), 12);

        // Fresh mul/div: exactly three BUSY cycles, stall count 3
        do_reset();
        step(mk(1, 0, 0, 0, 0, 0, 0, E_DEF), "md pulse");
        for (int k = 0; k < 3; k++)
            step(mk(0, 0, 0, 0, 0, 0, 0, E_BUSY), $sformatf("md busy%0d", k));
        step(mk(0, 0, 0, 0, 0, 0, 0, E_DEF), "md done");
        check("md stall total", int'(stall_cnt_o), 3);

        // Reset asserted during the second BUSY cycle
        step(mk(1, 0, 0, 0, 0, 0, 0, E_DEF), "rb pulse");
        step(mk(0, 0, 0, 0, 0, 0, 0, E_BUSY), "rb busy0");
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_stall = 0;
        #1;
        check("rb busy async", int'(md_busy_o), 0);
        check("rb stall async", int'(stall_cnt_o), 0);
        check("rb ctrl in reset", int'(got_ctrl()), int'(E_RST));
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rb ctrl release", int'(got_ctrl()), int'(E_DEF));
        step(mk(0, 0, 0, 0, 0, 0, 0, E_DEF), "rb after");

        // 300 consecutive load-use cycles saturate the counter
        for (int k = 0; k < 300; k++)
            step(mk(0, 1, 7, 7, 0, 0, 0, E_LU), $sformatf("sat%0d", k));
        check("sat final", int'(stall_cnt_o), 255);
        step(mk(0, 0, 0, 0, 0, 0, 0, E_DEF), "sat idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block that drives the `write` (hold) and `flush` (bubble) controls of the IF/ID and ID/EX pipeline registers, plus the PC write enable. It detects load-use hazards, squashes wrong-path instructions on a taken branch resolved in EX, and freezes the front end while a multi-cycle multiply/divide occupies EX. A saturating stall counter is provided for performance measurement. It sits beside the decode stage, and its outputs connect directly to the pipeline registers' write/flush inputs.

## Interface
- `MD_LATENCY`, default 4: total EX-stage cycles of a multi-cycle op; legal range 1..16.
- `REG_W`, default 5: register index width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `id_rs_i`  in  REG_W  rs index of the instruction in ID.
- `id_rt_i`  in  REG_W  rt index of the instruction in ID.
- `id_uses_rt_i`  in  1  ID instruction reads rt as a source.
- `id_md_i`  in  1  ID instruction is a multi-cycle mul/div.
- `ex_memread_i`  in  1  EX instruction is a load.
- `ex_rt_i`  in  REG_W  load destination index in EX.
- `ex_branch_taken_i`  in  1  branch in EX resolved taken.
- `pc_write_o`  out  1  PC update enable.
- `ifid_write_o`  out  1  IF/ID write enable.
- `ifid_flush_o`  out  1  IF/ID clear.
- `idex_write_o`  out  1  ID/EX write enable.
- `idex_flush_o`  out  1  ID/EX clear (bubble).
- `exmem_flush_o`  out  1  EX/MEM clear (bubble while EX is busy).
- `md_busy_o`  out  1  FSM is in BUSY.
- `stall_cnt_o`  out  8  count of cycles with `pc_write_o`=0, saturating.

## Operation
- **Hazard signals (combinational):**
  - `lu` = `ex_memread_i` & (`ex_rt_i`≠0) & ((`ex_rt_i`==`id_rs_i`) | (`id_uses_rt_i` & `ex_rt_i`==`id_rt_i`)).
  - `br` = `ex_branch_taken_i`.
- **Default outputs:** all write enables 1, all flushes 0, `md_busy_o`=0.
- **Priority, highest first:**
  - Reset active: all write enables 0, all flushes 1.
  - FSM in BUSY: `pc_write_o`, `ifid_write_o`, `idex_write_o` = 0; `exmem_flush_o`=1; all other flushes 0. `br` and `lu` are ignored.
  - `br`: `ifid_flush_o`=1, `idex_flush_o`=1, `pc_write_o`=1. `br` overrides `lu`.
  - `lu`: `pc_write_o`=0, `ifid_write_o`=0, `idex_flush_o`=1. Lasts one cycle, because the load then advances out of EX.
- **FSM states:** IDLE and BUSY, with a 4-bit down-counter `cnt`.
  - IDLE→BUSY when `id_md_i` & !`br` & !`lu` & `MD_LATENCY`>1. On that edge `cnt` loads `MD_LATENCY`-1.
  - BUSY: `cnt` decrements each edge. The FSM returns to IDLE on the edge where `cnt`==1.
  - BUSY therefore lasts exactly `MD_LATENCY`-1 cycles. The op completes on its final EX cycle, which is spent in IDLE.
  - If `MD_LATENCY`==1, BUSY is never entered.
  - Back-to-back mul/div ops: on the exit cycle (IDLE), a new `id_md_i` re-enters BUSY on the next edge.
- **Stall counter:** `stall_cnt_o` increments on each edge where `pc_write_o`=0, and holds at 255.

## Timing
- **Reset values:** FSM=IDLE, `cnt`=0, `stall_cnt_o`=0, `md_busy_o`=0. Assertion takes effect immediately without waiting for a clock edge.
- **Reset mid-BUSY:** FSM returns to IDLE asynchronously. After release, the first cycle shows the default outputs, given no hazard.
- **Latency:**
  - Hazard outputs respond combinationally, within the same cycle as their inputs.
  - FSM-derived outputs (`md_busy_o`, BUSY-forced outputs) change one edge after the entry condition.
  - `stall_cnt_o` is registered and reflects a stall one edge after the stalled cycle.
- **Simultaneous events:**
  - `br` together with `id_md_i`: the mul/div is squashed and there is no BUSY entry.
  - `lu` together with `id_md_i`: the mul/div is held in ID and BUSY is entered after the stall clears.

## Test plan
- **Load-use stall:**
  - Stimulus: `ex_memread_i`=1, `ex_rt_i`=8, `id_rs_i`=8.
  - Required: `pc_write_o`=0, `ifid_write_o`=0, `idex_flush_o`=1 for one cycle; `stall_cnt_o` goes 0→1.
- **No false stall on $zero:**
  - Stimulus: `ex_memread_i`=1, `ex_rt_i`=0, `id_rs_i`=0.
  - Required: default outputs, `stall_cnt_o` unchanged.
- **Branch overrides load-use:**
  - Stimulus: `br`=1 with a load-use match in the same cycle.
  - Required: `ifid_flush_o`=`idex_flush_o`=1, `pc_write_o`=1.
- **Multi-cycle stall, `MD_LATENCY`=4:**
  - Stimulus: `id_md_i` pulsed for one cycle.
  - Required: `md_busy_o` high for exactly 3 cycles starting one edge later, with `exmem_flush_o`=1 throughout; `stall_cnt_o`=3 afterwards.
- **Reset mid-BUSY:**
  - Stimulus: `rst_i` driven low during the 2nd BUSY cycle.
  - Required: `md_busy_o`=0 and `stall_cnt_o`=0 immediately; default outputs after release.
- **Saturation:**
  - Stimulus: 300 consecutive load-use stall cycles.
  - Required: `stall_cnt_o` holds at 255.
